// File: rtl/adc_joystick_sequencer_if.sv
// Bus bundle for the joystick ADC sequencer: frame pulse in, SPI pins,
// and the published X/Y pair with its status flags.
interface adc_joystick_sequencer_if;
    logic        frame;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_mosi;
    logic        adc_miso;
    logic [11:0] ch0;
    logic [11:0] ch1;
    logic        data_valid;
    logic        busy;
    logic        overrun;

    // Sequencer side: owns the SPI pins and the published results.
    modport master (
        input  frame,
        input  adc_miso,
        output adc_cs_n,
        output adc_sclk,
        output adc_mosi,
        output ch0,
        output ch1,
        output data_valid,
        output busy,
        output overrun
    );

    // Environment side: timing generator, ADC and drawing logic.
    modport slave (
        output frame,
        output adc_miso,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_mosi,
        input  ch0,
        input  ch1,
        input  data_valid,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/adc_joystick_sequencer.sv
// adc_joystick_sequencer: frame-paced SPI master for an MCP3202-style
// 2-channel 12-bit ADC. Each frame converts channel 0 then channel 1 and
// publishes both results in the same cycle so X/Y never tear.
module adc_joystick_sequencer #(
    parameter int unsigned CLK_DIV    = 13,
    parameter logic [11:0] RESET_CODE = 12'h800
) (
    input  logic                      clk25,
    input  logic                      rst,
    adc_joystick_sequencer_if.master  bus
);

    localparam logic [7:0] DIV_LAST       = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT       = 5'd17;
    localparam logic [4:0] FIRST_DATA_BIT = 5'd6;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HIGH,
        PUBLISH
    } state_t;

    state_t      state_q,   state_d;
    logic [7:0]  phase_q,   phase_d;
    logic [4:0]  bit_q,     bit_d;
    logic        chan_q,    chan_d;
    logic        frame_q,   frame_d;
    logic        pending_q, pending_d;
    logic [11:0] shift_q,   shift_d;
    logic [11:0] stage_q,   stage_d;
    logic        cs_n_q,    cs_n_d;
    logic        sclk_q,    sclk_d;
    logic        mosi_q,    mosi_d;
    logic [11:0] ch0_q,     ch0_d;
    logic [11:0] ch1_q,     ch1_d;
    logic        dv_q,      dv_d;
    logic        busy_q,    busy_d;
    logic        overrun_q, overrun_d;

    logic        phase_end;
    logic [4:0]  bit_next;

    // Command bits 1..4 are start, SGL/DIFF, ODD, MSBF; the rest are don't-care zeros.
    function automatic logic cmd_bit(input logic [4:0] n, input logic odd);
        case (n)
            5'd1, 5'd2, 5'd4: return 1'b1;
            5'd3:             return odd;
            default:          return 1'b0;
        endcase
    endfunction

    // Next-state logic for the sequencer, frame queueing and SPI pins.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        chan_d    = chan_q;
        frame_d   = bus.frame;
        pending_d = pending_q;
        shift_d   = shift_q;
        stage_d   = stage_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ch0_d     = ch0_q;
        ch1_d     = ch1_q;
        dv_d      = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        phase_end = (phase_q == DIV_LAST);
        bit_next  = bit_q + 5'd1;

        // A start in IDLE consumes the pending request; a simultaneous new
        // frame takes its place. Outside IDLE, one frame queues, more overrun.
        if (state_q == IDLE) begin
            pending_d = pending_q & frame_q;
        end else if (frame_q) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_q || pending_q) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    chan_d  = 1'b0;
                    phase_d = '0;
                    shift_d = '0;
                end
            end

            CS_SETUP: begin
                if (phase_end) begin
                    phase_d = '0;
                    bit_d   = 5'd1;
                    mosi_d  = cmd_bit(5'd1, chan_q);
                    state_d = SHIFT;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            SHIFT: begin
                if (!phase_end) begin
                    phase_d = phase_q + 8'd1;
                end else begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK edge: sample DOUT, keep only the 12 data periods.
                        sclk_d = 1'b1;
                        if (bit_q >= FIRST_DATA_BIT) begin
                            shift_d = {shift_q[10:0], bus.adc_miso};
                        end
                    end else begin
                        // Falling SCLK edge: start of the next low phase, MOSI moves here only.
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = CS_HIGH;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            bit_d   = '0;
                        end else begin
                            bit_d  = bit_next;
                            mosi_d = cmd_bit(bit_next, chan_q);
                        end
                    end
                end
            end

            CS_HIGH: begin
                // Two CLK_DIV-long halves, tracked in bit_q so the phase counter stays 8 bits.
                if (!phase_end) begin
                    phase_d = phase_q + 8'd1;
                end else begin
                    phase_d = '0;
                    if (bit_q == 5'd0) begin
                        bit_d = 5'd1;
                    end else begin
                        bit_d = '0;
                        if (!chan_q) begin
                            chan_d  = 1'b1;
                            stage_d = shift_q;
                            shift_d = '0;
                            cs_n_d  = 1'b0;
                            state_d = CS_SETUP;
                        end else begin
                            ch0_d   = stage_q;
                            ch1_d   = shift_q;
                            dv_d    = 1'b1;
                            state_d = PUBLISH;
                        end
                    end
                end
            end

            PUBLISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            chan_q    <= 1'b0;
            frame_q   <= 1'b0;
            pending_q <= 1'b0;
            shift_q   <= '0;
            stage_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ch0_q     <= RESET_CODE;
            ch1_q     <= RESET_CODE;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            chan_q    <= chan_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            stage_q   <= stage_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.adc_cs_n   = cs_n_q;
    assign bus.adc_sclk   = sclk_q;
    assign bus.adc_mosi   = mosi_q;
    assign bus.ch0        = ch0_q;
    assign bus.ch1        = ch1_q;
    assign bus.data_valid = dv_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_adc_joystick_sequencer.sv
// Testbench for adc_joystick_sequencer: MCP3202-like ADC model driven by
// decoded command bits, bus monitors, and per-scenario checks.
module tb_adc_joystick_sequencer;
    localparam int unsigned D       = 13;
    localparam int unsigned SEQ_LAT = 1 + 74 * D;

    logic clk25 = 1'b0;
    logic rst   = 1'b0;
    logic frame_drv = 1'b0;
    logic adc_dout  = 1'b0;

    adc_joystick_sequencer_if bus ();

    assign bus.frame    = frame_drv;
    assign bus.adc_miso = adc_dout;

    adc_joystick_sequencer #(.CLK_DIV(D), .RESET_CODE(12'h800)) dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    always @(posedge clk25) cyc <= cyc + 1;

    // ADC model: decode command on SCLK rises, serve code on SCLK falls.
    logic [11:0] code0, code1;
    int          rise_cnt = 0;
    logic [16:0] cmd_bits = '0;
    logic [16:0] win_cmd_q[$];
    int          win_rise_q[$];

    always @(posedge bus.adc_sclk or negedge bus.adc_cs_n) begin
        if (!bus.adc_sclk) begin
            rise_cnt = 0;
            cmd_bits = '0;
        end else if (!bus.adc_cs_n) begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt <= 17) cmd_bits[rise_cnt-1] = bus.adc_mosi;
        end
    end

    always @(negedge bus.adc_sclk) begin
        if (!bus.adc_cs_n) begin
            if (rise_cnt + 1 >= 6 && rise_cnt + 1 <= 17)
                adc_dout = cmd_bits[2] ? code1[16-rise_cnt] : code0[16-rise_cnt];
            else
                adc_dout = 1'($urandom);
        end
    end

    always @(posedge bus.adc_cs_n) begin
        if (rst) begin
            win_cmd_q.push_back(cmd_bits);
            win_rise_q.push_back(rise_cnt);
        end
    end

    // Bus monitor sampled on the falling clk25 edge.
    int unsigned dv_cyc = 0;
    int dv_cnt = 0, cs_falls = 0, tear_err = 0, hi_bad = 0, lo_bad = 0;
    int hi_run = 0, lo_run = 0, mon_rises = 0, gap_cnt = 0, last_gap = 0;
    logic prev_sclk, prev_cs;
    logic [11:0] prev_ch0, prev_ch1;

    always @(negedge clk25) begin
        if (!rst) begin
            hi_run = 0; lo_run = 0; gap_cnt = 0; mon_rises = 0;
        end else begin
            if (bus.data_valid) begin
                dv_cnt = dv_cnt + 1;
                dv_cyc = cyc;
            end
            if ((bus.ch0 !== prev_ch0 || bus.ch1 !== prev_ch1) && !bus.data_valid)
                tear_err = tear_err + 1;
            if (prev_cs && !bus.adc_cs_n) begin
                cs_falls = cs_falls + 1;
                mon_rises = 0;
                lo_run = 0;
            end
            if (bus.adc_sclk) hi_run = hi_run + 1;
            if (prev_sclk && !bus.adc_sclk) begin
                if (hi_run != D) hi_bad = hi_bad + 1;
                hi_run = 0;
            end
            if (!prev_sclk && bus.adc_sclk) begin
                if (lo_run != ((mon_rises == 0) ? 2 * D : D)) lo_bad = lo_bad + 1;
                mon_rises = mon_rises + 1;
                lo_run = 0;
            end
            if (!bus.adc_cs_n && !bus.adc_sclk) lo_run = lo_run + 1;
            if (!bus.busy) gap_cnt = 0;
            else if (bus.adc_cs_n) gap_cnt = gap_cnt + 1;
            else if (gap_cnt > 0) begin
                last_gap = gap_cnt;
                gap_cnt = 0;
            end
        end
        prev_sclk = bus.adc_sclk;
        prev_cs   = bus.adc_cs_n;
        prev_ch0  = bus.ch0;
        prev_ch1  = bus.ch1;
    end

    logic [11:0] pub0 = 12'h800, pub1 = 12'h800;

    task automatic pulse_frame(output int unsigned t);
        @(negedge clk25);
        frame_drv = 1'b1;
        @(posedge clk25);
        #1;
        t = cyc;
        frame_drv = 1'b0;
    endtask

    task automatic wait_dv(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk25);
            #1;
            if (dv_cnt > n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (5) @(negedge clk25);
        total++; if (bus.ch0 !== 12'h800) begin bad++; $display("FAIL rst_ch0: got %h want 800", bus.ch0); end
        total++; if (bus.ch1 !== 12'h800) begin bad++; $display("FAIL rst_ch1: got %h want 800", bus.ch1); end
        total++; if (bus.adc_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", bus.adc_cs_n); end
        total++; if (bus.adc_sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", bus.adc_sclk); end
        total++; if (bus.adc_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", bus.adc_mosi); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_dv: got %b want 0", bus.data_valid); end
        rst = 1'b1;
        repeat (100) @(negedge clk25);
        total++; if (cs_falls !== 0) begin bad++; $display("FAIL idle_no_spi: got %0d cs falls want 0", cs_falls); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single;
        int unsigned t;
        int n, f0;
        bit ok;
        code0 = 12'hABC; code1 = 12'h123;
        win_cmd_q.delete(); win_rise_q.delete();
        n = dv_cnt; f0 = cs_falls;
        pulse_frame(t);
        wait_dv(n, SEQ_LAT + 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_dv_seen: got timeout want data_valid"); end
        total++; if (dv_cyc !== t + SEQ_LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", dv_cyc - t, SEQ_LAT); end
        total++; if (bus.ch0 !== 12'hABC) begin bad++; $display("FAIL single_ch0: got %h want abc", bus.ch0); end
        total++; if (bus.ch1 !== 12'h123) begin bad++; $display("FAIL single_ch1: got %h want 123", bus.ch1); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_pub: got %b want 1", bus.busy); end
        @(negedge clk25); #1;
        total++; if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin bad++; $display("FAIL single_after_pub: got busy=%b dv=%b want 0 0", bus.busy, bus.data_valid); end
        total++; if (cs_falls - f0 !== 2) begin bad++; $display("FAIL single_cs_windows: got %0d want 2", cs_falls - f0); end
        total++; if (win_rise_q.size() !== 2) begin bad++; $display("FAIL single_windows_logged: got %0d want 2", win_rise_q.size()); end
        if (win_rise_q.size() >= 2) begin
            total++; if (win_rise_q[0] !== 17 || win_rise_q[1] !== 17) begin bad++; $display("FAIL single_rises: got %0d,%0d want 17,17", win_rise_q[0], win_rise_q[1]); end
            total++; if (win_cmd_q[0][3:0] !== 4'b1011) begin bad++; $display("FAIL single_cmd_ch0: got %b want 1011 (bits4..1)", win_cmd_q[0][3:0]); end
            total++; if (win_cmd_q[1][3:0] !== 4'b1111) begin bad++; $display("FAIL single_cmd_ch1: got %b want 1111 (bits4..1)", win_cmd_q[1][3:0]); end
            total++; if (win_cmd_q[0][16:4] !== '0 || win_cmd_q[1][16:4] !== '0) begin bad++; $display("FAIL single_cmd_tail: got %h,%h want 0", win_cmd_q[0][16:4], win_cmd_q[1][16:4]); end
        end
        total++; if (hi_bad !== 0 || lo_bad !== 0) begin bad++; $display("FAIL single_sclk_timing: got hi_bad=%0d lo_bad=%0d want 0", hi_bad, lo_bad); end
        pub0 = 12'hABC; pub1 = 12'h123;
    endtask

    task automatic test_tearing;
        int unsigned t;
        int n;
        bit ok;
        logic [11:0] exp0, exp1;
        for (int it = 0; it < 4; it++) begin
            code0 = 12'($urandom); code1 = 12'($urandom);
            exp0 = code0;
            win_rise_q.delete(); win_cmd_q.delete();
            n = dv_cnt;
            pulse_frame(t);
            for (int i = 0; i < 40 * D && win_rise_q.size() < 1; i++) @(negedge clk25);
            #1;
            total++; if (win_rise_q.size() !== 1) begin bad++; $display("FAIL tear_conv0_end: got %0d windows want 1", win_rise_q.size()); end
            total++; if (bus.ch0 !== pub0 || bus.ch1 !== pub1) begin bad++; $display("FAIL tear_mid_hold: got %h/%h want %h/%h", bus.ch0, bus.ch1, pub0, pub1); end
            code0 = 12'($urandom); code1 = 12'($urandom);
            exp1 = code1;
            wait_dv(n, SEQ_LAT + 100, ok);
            total++; if (!ok || bus.ch0 !== exp0 || bus.ch1 !== exp1) begin bad++; $display("FAIL tear_publish: got ok=%b %h/%h want %h/%h", ok, bus.ch0, bus.ch1, exp0, exp1); end
            pub0 = exp0; pub1 = exp1;
        end
        total++; if (tear_err !== 0) begin bad++; $display("FAIL tear_outside_publish: got %0d changes want 0", tear_err); end
    endtask

    task automatic test_back_to_back;
        int unsigned t, t2, c1;
        int n, f0;
        bit ok;
        code0 = 12'($urandom); code1 = 12'($urandom);
        n = dv_cnt; f0 = cs_falls; last_gap = 0;
        pulse_frame(t);
        repeat (198) @(negedge clk25);
        pulse_frame(t2);
        wait_dv(n, SEQ_LAT + 100, ok);
        c1 = dv_cyc;
        total++; if (!ok) begin bad++; $display("FAIL b2b_first: got timeout want data_valid"); end
        wait_dv(n + 1, SEQ_LAT + 100, ok);
        total++; if (!ok || dv_cyc !== c1 + 1 + SEQ_LAT) begin bad++; $display("FAIL b2b_second: got ok=%b spacing %0d want %0d", ok, dv_cyc - c1, 1 + SEQ_LAT); end
        total++; if (bus.ch0 !== code0 || bus.ch1 !== code1) begin bad++; $display("FAIL b2b_values: got %h/%h want %h/%h", bus.ch0, bus.ch1, code0, code1); end
        total++; if (last_gap !== 2 * D) begin bad++; $display("FAIL b2b_cs_gap: got %0d want %0d", last_gap, 2 * D); end
        repeat (SEQ_LAT + 100) @(negedge clk25);
        total++; if (dv_cnt - n !== 2 || cs_falls - f0 !== 4) begin bad++; $display("FAIL b2b_count: got dv=%0d cs=%0d want 2 4", dv_cnt - n, cs_falls - f0); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
        pub0 = code0; pub1 = code1;
    endtask

    task automatic test_overrun;
        int unsigned t;
        int n, f0;
        code0 = 12'($urandom); code1 = 12'($urandom);
        n = dv_cnt; f0 = cs_falls;
        pulse_frame(t);
        repeat (198) @(negedge clk25);
        pulse_frame(t);
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
        repeat (198) @(negedge clk25);
        pulse_frame(t);
        repeat (3) @(negedge clk25);
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
        repeat (3 * SEQ_LAT) @(negedge clk25);
        total++; if (dv_cnt - n !== 2 || cs_falls - f0 !== 4) begin bad++; $display("FAIL ovr_count: got dv=%0d cs=%0d want 2 4", dv_cnt - n, cs_falls - f0); end
        total++; if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL ovr_sticky: got ovr=%b busy=%b want 1 0", bus.overrun, bus.busy); end
        pub0 = code0; pub1 = code1;
    endtask

    task automatic test_abort;
        int unsigned t;
        int n, i;
        bit ok;
        code0 = 12'($urandom); code1 = 12'($urandom);
        n = dv_cnt;
        pulse_frame(t);
        for (i = 0; i < 40 * D; i++) begin
            @(negedge clk25);
            if (bus.adc_cs_n === 1'b0 && rise_cnt == 8 && bus.adc_sclk === 1'b0) break;
        end
        total++; if (i >= 40 * D) begin bad++; $display("FAIL abort_reach_bit9: got timeout want bit 9"); end
        #5 rst = 1'b0;
        #1;
        total++; if (bus.adc_cs_n !== 1'b1 || bus.adc_sclk !== 1'b0) begin bad++; $display("FAIL abort_async: got cs_n=%b sclk=%b want 1 0", bus.adc_cs_n, bus.adc_sclk); end
        total++; if (bus.ch0 !== 12'h800 || bus.ch1 !== 12'h800) begin bad++; $display("FAIL abort_ch: got %h/%h want 800/800", bus.ch0, bus.ch1); end
        total++; if (bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_flags: got ovr=%b busy=%b want 0 0", bus.overrun, bus.busy); end
        repeat (4) @(negedge clk25);
        rst = 1'b1;
        repeat (20) @(negedge clk25);
        total++; if (dv_cnt !== n) begin bad++; $display("FAIL abort_no_dv: got %0d want %0d", dv_cnt, n); end
        code0 = 12'($urandom); code1 = 12'($urandom);
        win_rise_q.delete(); win_cmd_q.delete();
        pulse_frame(t);
        wait_dv(n, SEQ_LAT + 100, ok);
        total++; if (!ok || dv_cyc !== t + SEQ_LAT) begin bad++; $display("FAIL abort_rerun_latency: got ok=%b lat=%0d want %0d", ok, dv_cyc - t, SEQ_LAT); end
        total++; if (bus.ch0 !== code0 || bus.ch1 !== code1) begin bad++; $display("FAIL abort_rerun_values: got %h/%h want %h/%h", bus.ch0, bus.ch1, code0, code1); end
        total++; if (win_rise_q.size() !== 2) begin bad++; $display("FAIL abort_rerun_windows: got %0d want 2", win_rise_q.size()); end
        else begin
            total++; if (win_rise_q[0] !== 17 || win_rise_q[1] !== 17) begin bad++; $display("FAIL abort_rerun_rises: got %0d,%0d want 17,17", win_rise_q[0], win_rise_q[1]); end
        end
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        code0 = '0;
        code1 = '0;
        test_reset();
        test_single();
        test_tearing();
        test_back_to_back();
        test_overrun();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_joystick_sequencer.md
Name: adc_joystick_sequencer

Overview:
Frame-paced SPI master for a 2-channel 12-bit SAR ADC (MCP3202 command format) wired to the analogue joystick. On each frame pulse it converts channel 0, then channel 1. Both results are published together so the sprite/reticle drawing logic never sees a half-updated X/Y pair within a frame. It sits between the VGA timing generator (frame pulse) and the drawing logic (CH0/CH1 inputs).

Parameters:
CLK_DIV, 13, clk25 cycles per SCLK half-period (13 gives about 0.96 MHz SCLK); legal range 2..255
RESET_CODE, 12'h800, value of ch0/ch1 after reset (joystick dead-zone centre, so no sprite drift)

Ports:
clk25  in  1  system clock, 25 MHz
rst  in  1  asynchronous, active-low reset (0 = reset)
frame  in  1  one-cycle pulse, once per video frame; starts a conversion sequence
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  SPI clock, idle low
adc_mosi  out  1  command bits to ADC (DIN)
adc_miso  in  1  ADC data out (DOUT)
ch0  out  12  last channel-0 result (drawing CH0)
ch1  out  12  last channel-1 result (drawing CH1)
data_valid  out  1  one-cycle pulse when ch0/ch1 update
busy  out  1  high from sequence start until return to IDLE
overrun  out  1  sticky; set when a frame is dropped

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, adc_cs_n=1, adc_sclk=0, adc_mosi=0, ch0=ch1=RESET_CODE, data_valid=0, busy=0, overrun=0, pending=0, shift registers cleared. Reset mid-transfer aborts immediately: CS goes high and no output update occurs.
- All outputs are registered.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HIGH -> (channel 0 done: CS_SETUP for channel 1 | channel 1 done: PUBLISH) -> IDLE.
- IDLE: on frame=1 (or pending=1), clear pending, select channel 0, assert adc_cs_n=0 and busy=1 on the next edge.
- CS_SETUP: CLK_DIV cycles, adc_sclk=0.
- SHIFT: 17 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - adc_mosi changes only at the start of the low phase.
  - Bits 1..4: start=1, SGL/DIFF=1, ODD=channel select, MSBF=1. Bits 5..17: mosi=0.
  - adc_miso is sampled on the clk25 edge where adc_sclk rises.
  - The samples from periods 6..17 shift in MSB first (B11..B0). Periods 1..5 are discarded (null bit included).
- CS_HIGH: adc_sclk=0, adc_cs_n=1 for 2*CLK_DIV cycles (meets tCSH).
- One conversion takes 37*CLK_DIV cycles.
- Channel-0 result is held in a staging register.
- PUBLISH: 1 cycle. ch0 <= staged value, ch1 <= new value, data_valid=1, then busy=0 on the following edge.
- Latency: frame sampled at edge k; adc_cs_n falls at edge k+1; data_valid is high during the cycle after edge k+1+74*CLK_DIV (edge k+963 for CLK_DIV=13).
- frame while busy: if pending=0, set pending=1. The next sequence starts directly from IDLE on the cycle after PUBLISH.
- frame while busy with pending=1: the pulse is dropped and overrun is set. overrun clears only on reset.
- frame in the same cycle as PUBLISH: treated as "while busy" (it sets pending).
- ch0/ch1 change only in PUBLISH; they are stable for the whole of every other cycle.
- Counters: the phase counter is wide enough for CLK_DIV-1 (8 bits); the bit counter is 5 bits (1..17). No wrap beyond these bounds.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> ch0=ch1=12'h800, adc_cs_n=1, adc_sclk=0, busy=0, overrun=0. Release rst -> no SPI activity without frame.
- Single frame with an ADC model returning 12'hABC (ODD=0) and 12'h123 (ODD=1):
  - mosi bits 1..4 are 1,1,0,1 then 1,1,1,1 for the second conversion;
  - 17 SCLK rises per CS-low window; SCLK high/low each 13 cycles;
  - data_valid fires exactly 963 cycles after frame with ch0=12'hABC, ch1=12'h123.
- Tearing check: with the ADC model returning new codes, ch0 is unchanged between the two conversions; ch0 and ch1 change in the same cycle.
- Frame at cycle 200 of a sequence -> exactly one back-to-back second sequence; cs_n is high for 2*CLK_DIV between conversions; overrun=0.
- Two frames during one sequence -> one extra sequence only, overrun=1 and it stays 1 until reset.
- Assert rst=0 during SHIFT bit 9 -> adc_cs_n=1 and adc_sclk=0 asynchronously, ch0/ch1 return to 12'h800, no data_valid. A following frame runs a clean full sequence.
